// File: rtl/btn_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared definitions for the pushbutton debounce/pulse block:
//               debounce state encoding, default timing constants and a
//               helper used to size the shared counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    // Debounce FSM states: IDLE (stable low), CHK_HI (qualifying a press),
    // PRESSED (stable high), CHK_LO (qualifying a release).
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHK_HI  = 2'd1,
        ST_PRESSED = 2'd2,
        ST_CHK_LO  = 2'd3
    } deb_state_t;

    // 10 ms debounce, 500 ms initial repeat delay, 150 ms repeat period at 100 MHz.
    localparam int c_DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int c_DEF_REPEAT_DELAY    = 50000000;
    localparam int c_DEF_REPEAT_PERIOD   = 15000000;

    // Largest of three timing parameters; sizes the shared counter width.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : btn_debounce_ch
// Description : One pushbutton channel: 2-flop synchronizer, debounce FSM
//               with saturating qualification counter, debounced level and a
//               one-cycle rise flag marking CHK_HI -> PRESSED entry.
//               With BTN_AUTO_REPEAT_EN defined, also exports o_pressed.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
`ifdef BTN_AUTO_REPEAT_EN
    ,
    output logic o_pressed
`endif
);

    // The sample that causes the CHK_* entry counts as the first of the
    // DEBOUNCE_CYCLES, so the count finishes at DEBOUNCE_CYCLES-2.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    deb_state_t       r_state;
    deb_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             w_cnt_done;

    assign w_cnt_done = (r_cnt == c_CNT_LAST);

    // Two-flop synchronizer for the asynchronous button pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state logic: any contrary sample aborts a qualification phase.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_sync2) w_state_next = ST_CHK_HI;
            end
            ST_CHK_HI: begin
                if (!r_sync2)       w_state_next = ST_IDLE;
                else if (w_cnt_done) w_state_next = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (!r_sync2) w_state_next = ST_CHK_LO;
            end
            ST_CHK_LO: begin
                if (r_sync2)         w_state_next = ST_PRESSED;
                else if (w_cnt_done) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register, counter cleared on every state change, rise flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
            r_rise <= (r_state == ST_CHK_HI) && (w_state_next == ST_PRESSED);
        end
    end

    assign o_level = (r_state == ST_PRESSED) || (r_state == ST_CHK_LO);
    assign o_rise  = r_rise;
`ifdef BTN_AUTO_REPEAT_EN
    assign o_pressed = (r_state == ST_PRESSED);
`endif

endmodule
`default_nettype wire

// File: rtl/btn_debounce_pulse.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : btn_debounce_pulse
// Description : Debounces the left/right pushbuttons and produces mutually
//               exclusive single-cycle move pulses. A press is ignored while
//               the other button is held. Optional macro BTN_AUTO_REPEAT_EN
//               adds auto-repeat pulses while a single button stays pressed.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_pulse
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = c_DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = c_DEF_REPEAT_PERIOD
) (
    input  logic clk_100mhz,
    input  logic rst,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    output logic btn_left,
    output logic btn_right,
    output logic btn_left_level,
    output logic btn_right_level
);

    localparam int c_CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;

    // Index 0 is the left channel, index 1 the right channel.
    logic [1:0] w_raw;
    logic [1:0] w_level;
    logic [1:0] w_other_level;
    logic [1:0] w_rise;
    logic [1:0] w_press_ok;
    logic [1:0] w_fire;
    logic [1:0] w_fire_gated;
    logic [1:0] r_pulse;
`ifdef BTN_AUTO_REPEAT_EN
    logic [1:0] w_pressed;
    logic [1:0] w_rep_fire;
`endif

    assign w_raw         = {btn_right_raw, btn_left_raw};
    assign w_other_level = {w_level[0], w_level[1]};

    for (genvar i = 0; i < 2; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (c_CNT_W)
        ) u_ch (
            .clk       (clk_100mhz),
            .rst       (rst),
            .i_raw     (w_raw[i]),
            .o_level   (w_level[i]),
            .o_rise    (w_rise[i])
`ifdef BTN_AUTO_REPEAT_EN
            ,
            .o_pressed (w_pressed[i])
`endif
        );

        // A press only counts when the other button is released; when both
        // rise together each sees the other's level and both are dropped.
        assign w_press_ok[i] = w_rise[i] & ~w_other_level[i];

`ifdef BTN_AUTO_REPEAT_EN
        localparam logic [c_CNT_W-1:0] c_REP_DELAY  = c_CNT_W'(REPEAT_DELAY);
        localparam logic [c_CNT_W-1:0] c_REP_PERIOD = c_CNT_W'(REPEAT_PERIOD);
        localparam logic [c_CNT_W-1:0] c_REP_MAX    = '1;
        localparam logic [c_CNT_W-1:0] c_REP_ONE    = c_CNT_W'(1);

        logic               r_armed;
        logic               r_periodic;
        logic [c_CNT_W-1:0] r_rep_cnt;
        logic               w_hold;
        logic               w_rep_due;

        // Counter reads 1 in the cycle a pulse is visible, so a match at N
        // lands the next pulse exactly N cycles after the previous one.
        assign w_hold        = w_pressed[i] & ~w_other_level[i];
        assign w_rep_due     = r_periodic ? (r_rep_cnt == c_REP_PERIOD)
                                          : (r_rep_cnt == c_REP_DELAY);
        assign w_rep_fire[i] = r_armed & w_hold & w_rep_due;
        assign w_fire[i]     = w_press_ok[i] | w_rep_fire[i];

        // Repeat timer: armed by each emitted pulse, disarmed for good once
        // the button leaves PRESSED or the other button is held.
        always_ff @(posedge clk_100mhz or posedge rst) begin
            if (rst) begin
                r_armed    <= 1'b0;
                r_periodic <= 1'b0;
                r_rep_cnt  <= '0;
            end else if (w_fire_gated[i]) begin
                r_armed    <= 1'b1;
                r_periodic <= ~w_press_ok[i];
                r_rep_cnt  <= c_REP_ONE;
            end else if (r_armed && !w_hold) begin
                r_armed   <= 1'b0;
                r_rep_cnt <= '0;
            end else if (r_armed && (r_rep_cnt != c_REP_MAX)) begin
                r_rep_cnt <= r_rep_cnt + c_REP_ONE;
            end
        end
`else
        assign w_fire[i] = w_press_ok[i];
`endif
    end

    // Final guard keeping the two move pulses mutually exclusive.
    assign w_fire_gated = w_fire & ~{w_fire[0], w_fire[1]};

    // Registered move pulses.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_pulse <= '0;
        end else begin
            r_pulse <= w_fire_gated;
        end
    end

    assign btn_left        = r_pulse[0];
    assign btn_right       = r_pulse[1];
    assign btn_left_level  = w_level[0];
    assign btn_right_level = w_level[1];

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_pulse.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_btn_debounce_pulse
// Description : Scoreboard bench for btn_debounce_pulse. Each scenario's raw
//               waveform is fed to a behavioural model (run-length debounce,
//               pulse and repeat rules) that queues expected pulses and level
//               traces; a negedge monitor compares the DUT against them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_debounce_pulse;

    localparam int D    = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int MAXN = 200;

    logic clk_100mhz = 1'b0;
    logic rst = 1'b1;
    logic btn_left_raw = 1'b0;
    logic btn_right_raw = 1'b0;
    logic btn_left, btn_right, btn_left_level, btn_right_level;

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk_100mhz      (clk_100mhz),
        .rst             (rst),
        .btn_left_raw    (btn_left_raw),
        .btn_right_raw   (btn_right_raw),
        .btn_left        (btn_left),
        .btn_right       (btn_right),
        .btn_left_level  (btn_left_level),
        .btn_right_level (btn_right_level)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    typedef struct {
        int cyc;
        bit is_left;
    } pulse_t;

    pulse_t exp_q[$];
    bit     stim_l[MAXN];
    bit     stim_r[MAXN];
    bit     stim_rst[MAXN];
    bit     exp_lvl_l[MAXN];
    bit     exp_lvl_r[MAXN];
    int     checks = 0;
    int     errors = 0;
    int     cur_cyc = 0;
    int     phase = 0;     // 0 idle, 1 reset, 2 active, 3 drain
    string  cur_name = "init";

    function automatic void clear_stim();
        for (int t = 0; t < MAXN; t++) begin
            stim_l[t] = 1'b0;
            stim_r[t] = 1'b0;
            stim_rst[t] = 1'b0;
        end
    endfunction

    function automatic bit raw_of(input int c, input int t);
        return (c == 0) ? stim_l[t] : stim_r[t];
    endfunction

    // Reference: level flips after D consecutive opposite synchronized
    // samples; synchronized value is the raw pin two cycles earlier (0 until
    // two cycles after reset release). Press pulse one cycle after the level
    // rises unless the other level is high; repeats at +RD then every +RP
    // while held in PRESSED (level high, last sample high) with the other low.
    function automatic void build_model(input int n);
        bit syn[2][MAXN];
        bit lvl[2][MAXN];
        bit prs[2][MAXN];
        bit press[2][MAXN];
        bit pulse[2][MAXN];
        int seg;
        seg = 0;
        for (int t = 0; t < n; t++) begin
            for (int c = 0; c < 2; c++) begin
                syn[c][t] = 1'b0; lvl[c][t] = 1'b0; prs[c][t] = 1'b0;
                press[c][t] = 1'b0; pulse[c][t] = 1'b0;
            end
        end
        for (int t = 0; t < n; t++) begin
            if (stim_rst[t]) begin
                seg = t + 1;
            end else begin
                for (int c = 0; c < 2; c++) begin
                    bit prev;
                    bit run;
                    syn[c][t] = (t - 2 >= seg) ? raw_of(c, t - 2) : 1'b0;
                    prev = (t > seg) ? lvl[c][t-1] : 1'b0;
                    run = 1'b1;
                    for (int k = 1; k <= D; k++) begin
                        if (t - k < seg) run = 1'b0;
                        else if (syn[c][t-k] == prev) run = 1'b0;
                    end
                    lvl[c][t] = run ? ~prev : prev;
                    prs[c][t] = lvl[c][t] && (t > seg) && syn[c][t-1];
                end
            end
        end
        for (int t = 0; t + 1 < n; t++) begin
            for (int c = 0; c < 2; c++) begin
                if (lvl[c][t] && (t == 0 || !lvl[c][t-1]) && !lvl[1-c][t] && !stim_rst[t+1]) begin
                    press[c][t+1] = 1'b1;
                    pulse[c][t+1] = 1'b1;
                end
            end
        end
`ifdef BTN_AUTO_REPEAT_EN
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < n; p++) begin
                if (press[c][p]) begin
                    int last;
                    int q;
                    bit ok;
                    last = p;
                    q = p + RD;
                    ok = 1'b1;
                    while (ok && q < n) begin
                        for (int k = last; k < q; k++)
                            if (!(prs[c][k] && !lvl[1-c][k])) ok = 1'b0;
                        if (stim_rst[q]) ok = 1'b0;
                        if (ok) begin
                            pulse[c][q] = 1'b1;
                            last = q;
                            q = q + RP;
                        end
                    end
                end
            end
        end
`endif
        for (int t = 0; t < n; t++) begin
            exp_lvl_l[t] = lvl[0][t];
            exp_lvl_r[t] = lvl[1][t];
            if (pulse[0][t]) exp_q.push_back('{cyc: t, is_left: 1'b1});
            if (pulse[1][t]) exp_q.push_back('{cyc: t, is_left: 1'b0});
        end
    endfunction

    // Monitor: compares outputs mid-cycle against the model and pops pulses.
    always @(negedge clk_100mhz) begin
        pulse_t e;
        bit     exp_now;
        if (phase == 1) begin
            checks++;
            if ({btn_left, btn_right, btn_left_level, btn_right_level} != 4'b0000) begin
                errors++;
                $display("FAIL %s reset_state: got %b, expected 0000", cur_name,
                         {btn_left, btn_right, btn_left_level, btn_right_level});
            end
        end else if (phase == 2) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cur_cyc) begin
                e = exp_q.pop_front();
                checks++; errors++;
                $display("FAIL %s missed_pulse: got none, expected left=%0b at cycle %0d",
                         cur_name, e.is_left, e.cyc);
            end
            checks++;
            if (btn_left_level != exp_lvl_l[cur_cyc]) begin
                errors++;
                $display("FAIL %s level_left cycle %0d: got %0b, expected %0b",
                         cur_name, cur_cyc, btn_left_level, exp_lvl_l[cur_cyc]);
            end
            checks++;
            if (btn_right_level != exp_lvl_r[cur_cyc]) begin
                errors++;
                $display("FAIL %s level_right cycle %0d: got %0b, expected %0b",
                         cur_name, cur_cyc, btn_right_level, exp_lvl_r[cur_cyc]);
            end
            checks++;
            if (btn_left && btn_right) begin
                errors++;
                $display("FAIL %s mutex cycle %0d: got both pulses, expected at most one",
                         cur_name, cur_cyc);
            end
            exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == cur_cyc);
            if (btn_left || btn_right || exp_now) begin
                checks++;
                if (!exp_now) begin
                    errors++;
                    $display("FAIL %s unexpected_pulse cycle %0d: got L=%0b R=%0b, expected none",
                             cur_name, cur_cyc, btn_left, btn_right);
                end else begin
                    e = exp_q.pop_front();
                    if ({btn_left, btn_right} != {e.is_left, ~e.is_left}) begin
                        errors++;
                        $display("FAIL %s pulse cycle %0d: got L=%0b R=%0b, expected L=%0b R=%0b",
                                 cur_name, cur_cyc, btn_left, btn_right, e.is_left, ~e.is_left);
                    end
                end
            end
        end else if (phase == 3) begin
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++; errors++;
                $display("FAIL %s missed_pulse: got none, expected left=%0b at cycle %0d",
                         cur_name, e.is_left, e.cyc);
            end
        end
    end

    task automatic run_scenario(input string name, input int n);
        @(posedge clk_100mhz);
        #1;
        rst = 1'b1;
        btn_left_raw = 1'b0;
        btn_right_raw = 1'b0;
        cur_name = name;
        phase = 1;
        build_model(n);
        for (int t = 0; t < n; t++) begin
            @(posedge clk_100mhz);
            #1;
            rst = stim_rst[t];
            btn_left_raw = stim_l[t];
            btn_right_raw = stim_r[t];
            cur_cyc = t;
            phase = 2;
        end
        @(posedge clk_100mhz);
        #1;
        phase = 3;
        @(posedge clk_100mhz);
        #1;
        phase = 0;
    endtask

    task automatic fill_random(input int n);
        clear_stim();
        for (int c = 0; c < 2; c++) begin
            int t;
            bit v;
            t = 0;
            v = 1'($urandom_range(0, 1));
            if (c == 1 && ($urandom % 3) == 0) begin
                t = n;
            end
            while (t < n) begin
                int len;
                len = (($urandom % 3) == 0) ? $urandom_range(6, 45) : $urandom_range(1, 4);
                for (int k = 0; k < len && t < n; k++) begin
                    if (c == 0) stim_l[t] = v;
                    else        stim_r[t] = v;
                    t++;
                end
                v = ~v;
            end
        end
        if (($urandom % 3) == 0) begin
            int p;
            p = $urandom_range(20, n - 10);
            stim_rst[p] = 1'b1;
            if (($urandom % 2) == 0) stim_rst[p+1] = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk_100mhz);

        clear_stim();
        for (int t = 0; t < 20; t++) stim_l[t] = 1'b1;
        run_scenario("clean_press", 30);

        clear_stim();
        stim_r[0] = 1'b1; stim_r[2] = 1'b1;
        for (int t = 4; t < 25; t++) stim_r[t] = 1'b1;
        run_scenario("bounce", 35);

        clear_stim();
        for (int t = 0; t < 20; t++) begin
            stim_l[t] = 1'b1;
            stim_r[t] = 1'b1;
        end
        run_scenario("simultaneous", 30);

        clear_stim();
        for (int t = 0; t < 60; t++) stim_l[t] = 1'b1;
        run_scenario("auto_repeat", 80);

        clear_stim();
        for (int t = 0; t < 30; t++) stim_l[t] = 1'b1;
        stim_rst[5] = 1'b1; stim_rst[6] = 1'b1;
        run_scenario("reset_mid_debounce", 30);

        clear_stim();
        for (int t = 0; t < 40; t++) stim_l[t] = 1'b1;
        stim_rst[15] = 1'b1; stim_rst[16] = 1'b1;
        run_scenario("reset_while_pressed", 40);

        clear_stim();
        for (int t = 0; t < 40; t++) stim_l[t] = 1'b1;
        for (int t = 15; t < 26; t++) stim_r[t] = 1'b1;
        run_scenario("other_held", 60);

        for (int s = 0; s < 8; s++) begin
            fill_random(150);
            run_scenario($sformatf("random_%0d", s), 150);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
